// File: rtl/mode4_reduce_sequencer_pkg.sv
// Shared types and constants for the mode4 adder-tree reduction sequencer.
package mode4_reduce_sequencer_pkg;

    localparam int DATAWIDTH_DEFAULT = 16;
    localparam int LEN_WIDTH_DEFAULT = 8;

    // One fewer than the tree depth: stage1 and stage0 still have to fire after the last beat.
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mode4_run_pipe.sv
// Delays the stage2 run enable by one and two cycles to drive stage1 and stage0.
module mode4_run_pipe (
    input  logic clk,
    input  logic reset,
    input  logic stage2_run_i,
    output logic stage1_run_o,
    output logic stage0_run_o
);

    logic [1:0] pipe_q;

    // NOTE: non-blocking assignments let both shift bits sample the old value on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[0], stage2_run_i};
        end
    end

    assign stage1_run_o = pipe_q[0];
    assign stage0_run_o = pipe_q[1];

endmodule

// File: rtl/mode4_reduce_sequencer.sv
// Streams 4-word beats into the mode4 adder tree, sequences its run enables,
// and returns the accumulated sum with a valid/ready handshake.
module mode4_reduce_sequencer
    import mode4_reduce_sequencer_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
    parameter int LEN_WIDTH = LEN_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] num_beats,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data0,
    input  logic [DATAWIDTH-1:0] in_data1,
    input  logic [DATAWIDTH-1:0] in_data2,
    input  logic [DATAWIDTH-1:0] in_data3,
    output logic [DATAWIDTH-1:0] tree_inp0,
    output logic [DATAWIDTH-1:0] tree_inp1,
    output logic [DATAWIDTH-1:0] tree_inp2,
    output logic [DATAWIDTH-1:0] tree_inp3,
    output logic                 tree_stage2_run,
    output logic                 tree_stage1_run,
    output logic                 tree_stage0_run,
    output logic                 tree_rst,
    input  logic [DATAWIDTH-1:0] tree_outp,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [DATAWIDTH-1:0] result_data
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e               state_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic [DRAIN_W-1:0]   drain_q;

    logic [LEN_WIDTH:0]   cnt_d;
    logic                 last_beat;
    logic                 accept;
    logic                 stage1_run_raw;
    logic                 stage0_run_raw;

    // One extra bit so a full 2^LEN_WIDTH-1 beat run compares before the count can wrap.
    assign cnt_d     = {1'b0, cnt_q} + (LEN_WIDTH+1)'(1);
    assign last_beat = (cnt_d == {1'b0, len_q});
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q   <= num_beats;
                        state_q <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    cnt_q   <= '0;
                    drain_q <= '0;
                    state_q <= (len_q != '0) ? ST_STREAM : ST_DONE;
                end
                ST_STREAM: begin
                    if (accept) begin
                        cnt_q <= cnt_d[LEN_WIDTH-1:0];
                        if (last_beat) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        drain_q <= drain_q + DRAIN_W'(1);
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: reset is synchronous, so state still holds its old value during the reset cycle;
    // outputs are qualified with reset to read as idle immediately.
    assign busy            = reset && (state_q != ST_IDLE);
    assign in_ready        = reset && (state_q == ST_STREAM);
    assign result_valid    = reset && (state_q == ST_DONE);
    assign result_data     = result_valid ? tree_outp : '0;
    assign tree_rst        = !reset || (state_q == ST_CLEAR);
    assign tree_stage2_run = accept;
    assign tree_stage1_run = reset && stage1_run_raw;
    assign tree_stage0_run = reset && stage0_run_raw;

    assign tree_inp0 = in_data0;
    assign tree_inp1 = in_data1;
    assign tree_inp2 = in_data2;
    assign tree_inp3 = in_data3;

    mode4_run_pipe u_run_pipe (
        .clk          (clk),
        .reset        (reset),
        .stage2_run_i (tree_stage2_run),
        .stage1_run_o (stage1_run_raw),
        .stage0_run_o (stage0_run_raw)
    );

endmodule
